accel_throttle_filter: RTL and testbench

Upstream neighbour of the motor PWM generator. Accepts raw signed accelerometer samples, smooths them with a power-of-two moving average, and rescales to 10 bits. A slew-rate limiter then produces the signed 10-bit throttle setting, which feeds the PWM generator's input directly. The slew limiter gives the motor a soft start and a soft stop.

---
 rtl/accel_throttle_filter_pkg.sv | 16 +
 rtl/accel_throttle_filter_if.sv | 25 ++
 rtl/accel_moving_avg.sv | 57 +++++
 rtl/accel_throttle_filter.sv | 130 +++++++++++++
 tb/tb_accel_throttle_filter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/accel_throttle_filter_pkg.sv
// Shared types and default widths for the accelerometer throttle filter.
// Optional deadband is enabled by defining FILTER_DEADBAND_EN.
package filter_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int OUT_W      = 10;
    localparam int LOG2_DEPTH = 3;

    typedef logic signed [SAMPLE_W+LOG2_DEPTH-1:0] sum_t;

    typedef enum logic {
        FILL,
        RUN
    } filter_state_t;

endpackage

// File: rtl/accel_throttle_filter_if.sv
// Sample-in / throttle-out bundle between accelerometer front end,
// throttle filter and PWM generator.
interface accel_throttle_filter_if #(
    parameter int SAMPLE_W = 12,
    parameter int OUT_W    = 10
);

    logic                       SampleValid;
    logic signed [SAMPLE_W-1:0] SampleData;
    logic                       Enable;
    logic signed [OUT_W-1:0]    FilterOut;
    logic                       OutValid;
    logic                       Filling;

    modport master (
        output SampleValid, SampleData, Enable,
        input  FilterOut, OutValid, Filling
    );

    modport slave (
        input  SampleValid, SampleData, Enable,
        output FilterOut, OutValid, Filling
    );

endinterface

// File: rtl/accel_moving_avg.sv
// Ring buffer with running sum over the last 2^LOG2_DEPTH samples.
// full marks a sum that covers a complete window.
module accel_moving_avg #(
    parameter int SAMPLE_W   = filter_pkg::SAMPLE_W,
    parameter int LOG2_DEPTH = filter_pkg::LOG2_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic signed [SAMPLE_W-1:0]            in_data,
    output logic signed [SAMPLE_W+LOG2_DEPTH-1:0] sum,
    output logic                                  sum_valid,
    output logic                                  full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = SAMPLE_W + LOG2_DEPTH;

    logic signed [SAMPLE_W-1:0] ring [DEPTH];
    logic [LOG2_DEPTH-1:0]      wptr;
    logic [LOG2_DEPTH:0]        fill_cnt;
    logic [LOG2_DEPTH:0]        fill_nxt;
    logic signed [SW-1:0]       new_x;
    logic signed [SW-1:0]       old_x;

    // Saturating fill count and sign-extended add/remove operands
    always_comb begin
        fill_nxt = fill_cnt;
        if (fill_cnt != (LOG2_DEPTH+1)'(DEPTH))
            fill_nxt = fill_cnt + 1'b1;
        new_x = {{LOG2_DEPTH{in_data[SAMPLE_W-1]}}, in_data};
        old_x = {{LOG2_DEPTH{ring[wptr][SAMPLE_W-1]}}, ring[wptr]};
    end

    // S1: overwrite oldest entry (read-before-write) and update sum
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                ring[i] <= '0;
            wptr      <= '0;
            fill_cnt  <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            sum_valid <= in_valid;
            if (in_valid) begin
                ring[wptr] <= in_data;
                sum        <= sum + new_x - old_x;
                wptr       <= wptr + 1'b1;
                fill_cnt   <= fill_nxt;
                full       <= (fill_nxt == (LOG2_DEPTH+1)'(DEPTH));
            end
        end
    end

endmodule

// File: rtl/accel_throttle_filter.sv
// Moving-average + slew-limited throttle for the PWM stage.
// Define FILTER_DEADBAND_EN to zero small targets (|target| < DEADBAND).
module accel_throttle_filter #(
    parameter int SAMPLE_W   = filter_pkg::SAMPLE_W,
    parameter int LOG2_DEPTH = filter_pkg::LOG2_DEPTH,
    parameter int OUT_W      = filter_pkg::OUT_W,
    parameter int SLEW_STEP  = 4,
    parameter int DEADBAND   = 16
) (
    input  logic                    Filterclock,
    input  logic                    Filterreset,
    accel_throttle_filter_if.slave  bus
);

    import filter_pkg::*;

    localparam int SW    = SAMPLE_W + LOG2_DEPTH;
    localparam int SHIFT = LOG2_DEPTH + SAMPLE_W - OUT_W;
    localparam logic signed [OUT_W:0]   STEP_X = (OUT_W+1)'(SLEW_STEP);
    localparam logic signed [OUT_W-1:0] STEP_O = OUT_W'(SLEW_STEP);

    logic                       s0_v;
    logic signed [SAMPLE_W-1:0] s0_d;
    logic signed [SW-1:0]       sum;
    logic                       sum_valid;
    logic                       full;
    logic signed [OUT_W-1:0]    tgt_pre;
    logic                       tgt_v;
    logic                       tgt_full;
    logic signed [OUT_W-1:0]    tgt;
    logic signed [OUT_W:0]      diff;
    filter_state_t              state;
    logic signed [OUT_W-1:0]    out_q;
    logic                       ov_q;
    logic                       fill_q;

    // Edge 0: capture the incoming sample
    always_ff @(posedge Filterclock) begin
        if (Filterreset) begin
            s0_v <= 1'b0;
            s0_d <= '0;
        end else begin
            s0_v <= bus.SampleValid;
            if (bus.SampleValid)
                s0_d <= bus.SampleData;
        end
    end

    accel_moving_avg #(
        .SAMPLE_W   (SAMPLE_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_avg (
        .clk       (Filterclock),
        .rst       (Filterreset),
        .in_valid  (s0_v),
        .in_data   (s0_d),
        .sum       (sum),
        .sum_valid (sum_valid),
        .full      (full)
    );

`ifdef FILTER_DEADBAND_EN
    logic signed [OUT_W-1:0] tgt_raw;
    logic signed [OUT_W:0]   tgt_ext;
    logic signed [OUT_W:0]   tgt_mag;

    // Rescale, then zero targets inside the deadband (-512 safe in OUT_W+1)
    always_comb begin
        tgt_raw = OUT_W'(sum >>> SHIFT);
        tgt_ext = {tgt_raw[OUT_W-1], tgt_raw};
        tgt_mag = (tgt_ext < 0) ? -tgt_ext : tgt_ext;
        tgt_pre = tgt_raw;
        if (tgt_mag < $signed((OUT_W+1)'(DEADBAND)))
            tgt_pre = '0;
    end
`else
    // Rescale window sum to the throttle range
    always_comb begin
        tgt_pre = OUT_W'(sum >>> SHIFT);
    end
`endif

    // S2: register target, forced to zero while disabled
    always_ff @(posedge Filterclock) begin
        if (Filterreset) begin
            tgt_v    <= 1'b0;
            tgt_full <= 1'b0;
            tgt      <= '0;
        end else begin
            tgt_v <= sum_valid;
            if (sum_valid) begin
                tgt      <= bus.Enable ? tgt_pre : '0;
                tgt_full <= full;
            end
        end
    end

    // Distance from current throttle to target
    always_comb begin
        diff = {tgt[OUT_W-1], tgt} - {out_q[OUT_W-1], out_q};
    end

    // S3: fill/run state machine and slew-limited throttle update
    always_ff @(posedge Filterclock) begin
        if (Filterreset) begin
            state  <= FILL;
            out_q  <= '0;
            ov_q   <= 1'b0;
            fill_q <= 1'b1;
        end else begin
            ov_q <= 1'b0;
            if (tgt_v && (tgt_full || state == RUN)) begin
                state  <= RUN;
                fill_q <= 1'b0;
                ov_q   <= 1'b1;
                if (diff > STEP_X)
                    out_q <= out_q + STEP_O;
                else if (diff < -STEP_X)
                    out_q <= out_q - STEP_O;
                else
                    out_q <= tgt;
            end
        end
    end

    assign bus.FilterOut = out_q;
    assign bus.OutValid  = ov_q;
    assign bus.Filling   = fill_q;

endmodule

// File: tb/tb_accel_throttle_filter.sv
// Randomized bench for accel_throttle_filter against a window/slew model.
// Honours FILTER_DEADBAND_EN in the model as well.
module tb_accel_throttle_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    accel_throttle_filter_if #(.SAMPLE_W(12), .OUT_W(10)) bus ();

    accel_throttle_filter dut (
        .Filterclock (clk),
        .Filterreset (rst),
        .bus         (bus)
    );

    typedef struct {
        int v;
        int c;
    } exp_t;

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   nout   = 0;
    exp_t expq[$];
    int   win[$];
    int   cnt    = 0;
    int   mout   = 0;
    int   cur    = 0;
    bit   en     = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.OutValid) begin
            if (expq.size() == 0) begin
                chk("spurious_outvalid", 1, 0);
            end else begin
                e = expq.pop_front();
                nout++;
                chk("filter_out", int'(bus.FilterOut), e.v);
                chk("latency", cyc, e.c);
                chk("filling_run", int'(bus.Filling), 0);
                cur = e.v;
            end
        end else begin
            chk("hold", int'(bus.FilterOut), cur);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic model_clear();
        win.delete();
        expq.delete();
        cnt  = 0;
        mout = 0;
        cur  = 0;
    endtask

    task automatic send(input int d);
        logic signed [11:0] s12;
        int s;
        int t;
        int df;
        exp_t e;
        s12 = d[11:0];
        bus.SampleValid = 1'b1;
        bus.SampleData  = s12;
        win.push_back(int'(s12));
        if (win.size() > 8)
            void'(win.pop_front());
        cnt++;
        if (cnt >= 8) begin
            s = 0;
            foreach (win[i])
                s += win[i];
            t = en ? (s >>> 5) : 0;
`ifdef FILTER_DEADBAND_EN
            if (t < 16 && t > -16)
                t = 0;
`endif
            df = t - mout;
            if (df > 4)
                mout = mout + 4;
            else if (df < -4)
                mout = mout - 4;
            else
                mout = t;
            e.v = mout;
            e.c = cyc + 4;
            expq.push_back(e);
        end
        step();
        bus.SampleValid = 1'b0;
    endtask

    task automatic set_en(input bit v);
        idle(4);
        bus.Enable = v;
        en = v;
    endtask

    task automatic do_reset();
        model_clear();
        rst = 1'b1;
        bus.SampleValid = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        bus.SampleValid = 1'b0;
        bus.SampleData  = '0;
        bus.Enable      = 1'b1;
        en              = 1'b1;
        do_reset();
        chk("rst_out", int'(bus.FilterOut), 0);
        chk("rst_valid", int'(bus.OutValid), 0);
        chk("rst_filling", int'(bus.Filling), 1);

        // ramp up to 256, then hold
        for (int i = 0; i < 72; i++) begin
            send(32'h400);
            idle(3);
        end
        chk("t1_final", int'(bus.FilterOut), 256);

        // small step up tracked exactly
        for (int i = 0; i < 8; i++) begin
            send(32'h408);
            idle(3);
        end
        chk("t3_final", int'(bus.FilterOut), 258);

        // soft stop, then restart
        set_en(1'b0);
        for (int i = 0; i < 70; i++) begin
            send(32'h400);
            idle(3);
        end
        chk("t4_stopped", int'(bus.FilterOut), 0);
        set_en(1'b1);
        for (int i = 0; i < 5; i++) begin
            send(32'h400);
            idle(3);
        end
        chk("t4_restart", int'(bus.FilterOut), 20);

        // full negative scale
        do_reset();
        for (int i = 0; i < 140; i++)
            send(32'h800);
        idle(5);
        chk("t2_final", int'(bus.FilterOut), -512);

        // reset right after a sample in RUN
        idle(4);
        send(32'h123);
        model_clear();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_out", int'(bus.FilterOut), 0);
        chk("t5_filling", int'(bus.Filling), 1);
        chk("t5_valid", int'(bus.OutValid), 0);
        for (int i = 0; i < 7; i++) begin
            send($urandom);
            idle(1);
        end
        idle(4);
        chk("t5_still_fill", int'(bus.Filling), 1);

        // back-to-back samples
        do_reset();
        n0 = nout;
        for (int i = 0; i < 16; i++)
            send($urandom);
        idle(5);
        chk("t6_count", nout - n0, 9);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3)
                set_en(~en);
            if ($urandom_range(0, 199) == 0)
                do_reset();
            send($urandom);
            idle($urandom_range(0, 3));
        end
        idle(6);
        chk("drain", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
